// File: rtl/clock_time_ctrl.sv
// Sequencer for the clock datapath: 1 Hz tick, carry-chained counter
// enables in RUN, and button-driven hour/minute editing in SET modes.
//
// Ports:
//   clk       system clock, rising edge
//   clr       synchronous active-low reset
//   mode_btn  one-cycle pulse, steps RUN -> SET_HR -> SET_MIN -> RUN
//   inc_btn   one-cycle pulse, increments the field being edited
//   sec_co    seconds counter at 59
//   min_co    minutes counter at 59
//   min_q1/0  current minute digits
//   hr_q1/0   current hour digits
//   sec_clr   clears seconds on entry to SET_HR
//   sec_en    seconds count enable
//   min_en    minutes count enable
//   min_load  minutes load strobe, data on min_d1/min_d0
//   hr_en     hours count enable
//   hr_load   hours load strobe, data on hr_d1/hr_d0
//   mode      00 RUN, 01 SET_HR, 10 SET_MIN
//   blink     blink gate for the field being edited
module clock_time_ctrl #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       sec_co,
    input  logic       min_co,
    input  logic [3:0] min_q0,
    input  logic [2:0] min_q1,
    input  logic [3:0] hr_q0,
    input  logic [1:0] hr_q1,
    output logic       sec_clr,
    output logic       sec_en,
    output logic       min_en,
    output logic       min_load,
    output logic [3:0] min_d0,
    output logic [2:0] min_d1,
    output logic       hr_en,
    output logic       hr_load,
    output logic [3:0] hr_d0,
    output logic [1:0] hr_d1,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PHALF = PW'(CLK_DIV / 2);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_nx;
    logic            tick;
    logic            act;
    logic            hr_ok;
    logic            min_ok;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= RUN;
            pre   <= '0;
        end else begin
            state <= state_nx;
            pre   <= pre_nx;
        end
    end

    // Prescaler free-runs in every mode (it also paces blink) and
    // restarts on each mode change so RUN always resumes with a full
    // second before the first tick.
    always_comb begin
        state_nx = state;
        pre_nx   = pre + PW'(1);
        if (pre == PMAX) begin
            pre_nx = '0;
        end
        if (mode_btn) begin
            pre_nx = '0;
            unique case (state)
                RUN:     state_nx = SET_HR;
                SET_HR:  state_nx = SET_MIN;
                SET_MIN: state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    // Hour is valid and below 23; anything else wraps to 00.
    always_comb begin
        hr_ok = (hr_q0 <= 4'd9) &&
                ((hr_q1 < 2'd2) ||
                 ((hr_q1 == 2'd2) && (hr_q0 < 4'd3)));
        hr_d0 = 4'd0;
        hr_d1 = 2'd0;
        if (hr_ok) begin
            if (hr_q0 == 4'd9) begin
                hr_d0 = 4'd0;
                hr_d1 = hr_q1 + 2'd1;
            end else begin
                hr_d0 = hr_q0 + 4'd1;
                hr_d1 = hr_q1;
            end
        end
    end

    // Minute is valid and below 59; anything else wraps to 00.
    always_comb begin
        min_ok = (min_q0 <= 4'd9) && (min_q1 <= 3'd5) &&
                 !((min_q1 == 3'd5) && (min_q0 == 4'd9));
        min_d0 = 4'd0;
        min_d1 = 3'd0;
        if (min_ok) begin
            if (min_q0 == 4'd9) begin
                min_d0 = 4'd0;
                min_d1 = min_q1 + 3'd1;
            end else begin
                min_d0 = min_q0 + 4'd1;
                min_d1 = min_q1;
            end
        end
    end

    // Pulses are gated by clr, and mode_btn overrides any enable or load
    // in the same cycle.
    always_comb begin
        tick     = (state == RUN) && (pre == PMAX);
        act      = clr && !mode_btn;
        sec_clr  = 1'b0;
        sec_en   = 1'b0;
        min_en   = 1'b0;
        hr_en    = 1'b0;
        min_load = 1'b0;
        hr_load  = 1'b0;
        unique case (state)
            RUN: begin
                sec_clr = clr && mode_btn;
                sec_en  = act && tick;
                min_en  = act && tick && sec_co;
                hr_en   = act && tick && sec_co && min_co;
            end
            SET_HR: begin
                hr_load = act && inc_btn;
            end
            SET_MIN: begin
                min_load = act && inc_btn;
            end
            default: begin
                sec_clr = 1'b0;
            end
        endcase
    end

    assign mode  = state;
    assign blink = (state != RUN) && (pre < PHALF);

endmodule
